spi_frame_deserializer: RTL and testbench

- Front end of the SPI slave. Directly upstream of the write/read register file.
- Samples the serial input pico on spi_clk and frames each chip-select window into one command byte followed by data bytes.
- Produces the address, write flag, write data, a one-cycle write strobe and a read-load pulse that the register file consumes.
- Addresses auto-increment across consecutive data bytes within a frame.

---
 rtl/spi_frame_deserializer.sv | 147 ++++++++++++++
 tb/tb_spi_frame_deserializer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_deserializer.sv
// SPI slave front end: frames each chip-select window into a command byte plus data
// bytes and produces the address, write data and strobes the register file consumes.
module spi_frame_deserializer #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter int MAX_ADDR = 11,
    parameter int AUTO_INC = 1
) (
    input  logic              spi_clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              pico,
    output logic [ADDR_W-1:0] addr,
    output logic              is_write,
    output logic [DATA_W-1:0] wdata,
    output logic              wr_strobe,
    output logic              rd_load,
    output logic              frame_active,
    output logic              addr_err,
    output logic [7:0]        byte_cnt
);

    typedef enum logic {CMD, DATA} state_t;

    localparam logic [ADDR_W-1:0] MAX_A = ADDR_W'(MAX_ADDR);

    logic clr;
    assign clr = rst | ~cs;

    state_t            state_q, state_d;
    logic [DATA_W-2:0] shift_q, shift_d;
    logic [2:0]        bitcnt_q, bitcnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              is_write_q, is_write_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_strobe_q, wr_strobe_d;
    logic              rd_load_q, rd_load_d;
    logic              frame_active_q, frame_active_d;
    logic              addr_err_q, addr_err_d;
    logic [7:0]        byte_cnt_q, byte_cnt_d;
    logic              inc_pend_q, inc_pend_d;

    logic [DATA_W-1:0] byte_w;
    logic [ADDR_W-1:0] cmd_addr;
    logic              done;
    logic              addr_ok;
    logic              cmd_addr_ok;

    always_ff @(posedge spi_clk or posedge clr) begin
        if (clr) begin
            state_q        <= CMD;
            shift_q        <= '0;
            bitcnt_q       <= '0;
            addr_q         <= '0;
            is_write_q     <= 1'b0;
            wdata_q        <= '0;
            wr_strobe_q    <= 1'b0;
            rd_load_q      <= 1'b0;
            frame_active_q <= 1'b0;
            addr_err_q     <= 1'b0;
            byte_cnt_q     <= '0;
            inc_pend_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            shift_q        <= shift_d;
            bitcnt_q       <= bitcnt_d;
            addr_q         <= addr_d;
            is_write_q     <= is_write_d;
            wdata_q        <= wdata_d;
            wr_strobe_q    <= wr_strobe_d;
            rd_load_q      <= rd_load_d;
            frame_active_q <= frame_active_d;
            addr_err_q     <= addr_err_d;
            byte_cnt_q     <= byte_cnt_d;
            inc_pend_q     <= inc_pend_d;
        end
    end

    always_comb begin
        byte_w      = {shift_q, pico};
        cmd_addr    = ADDR_W'(byte_w[DATA_W-2:0]);
        done        = (bitcnt_q == 3'd7);
        addr_ok     = (addr_q != '0) && (addr_q <= MAX_A);
        cmd_addr_ok = (cmd_addr != '0) && (cmd_addr <= MAX_A);

        state_d        = state_q;
        shift_d        = byte_w[DATA_W-2:0];
        bitcnt_d       = bitcnt_q + 3'd1;
        addr_d         = addr_q;
        is_write_d     = is_write_q;
        wdata_d        = wdata_q;
        wr_strobe_d    = 1'b0;
        rd_load_d      = 1'b0;
        frame_active_d = frame_active_q;
        addr_err_d     = addr_err_q;
        byte_cnt_d     = byte_cnt_q;
        inc_pend_d     = 1'b0;

        // Increment lands at the end of the strobe cycle so strobe and address stay aligned.
        if (inc_pend_q) begin
            if (AUTO_INC != 0) begin
                if (addr_q == MAX_A) begin
                    addr_d     = ADDR_W'(1);
                    addr_err_d = 1'b1;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            rd_load_d = ~is_write_q;
        end

        case (state_q)
            CMD: begin
                if (done) begin
                    is_write_d     = byte_w[DATA_W-1];
                    addr_d         = cmd_addr;
                    frame_active_d = 1'b1;
                    rd_load_d      = ~byte_w[DATA_W-1];
                    state_d        = DATA;
                    if (!cmd_addr_ok) addr_err_d = 1'b1;
                end
            end
            DATA: begin
                if (done) begin
                    wdata_d    = byte_w;
                    inc_pend_d = 1'b1;
                    if (byte_cnt_q != 8'hFF) byte_cnt_d = byte_cnt_q + 8'd1;
                    if (is_write_q) begin
                        if (addr_ok) wr_strobe_d = 1'b1;
                        else         addr_err_d  = 1'b1;
                    end
                end
            end
            default: state_d = CMD;
        endcase
    end

    assign addr         = addr_q;
    assign is_write     = is_write_q;
    assign wdata        = wdata_q;
    assign wr_strobe    = wr_strobe_q;
    assign rd_load      = rd_load_q;
    assign frame_active = frame_active_q;
    assign addr_err     = addr_err_q;
    assign byte_cnt     = byte_cnt_q;

endmodule

// File: tb/tb_spi_frame_deserializer.sv
// Bench for spi_frame_deserializer: frame-level model checked every cycle on two
// instances (auto-increment on and off) plus literal expectations at key points.
module tb_spi_frame_deserializer;

    localparam int MAX = 11;

    logic clk = 1'b0;
    logic rst, cs, pico;

    logic [6:0] a1_addr, a0_addr;
    logic       a1_iw, a0_iw, a1_ws, a0_ws, a1_rl, a0_rl, a1_fa, a0_fa, a1_ae, a0_ae;
    logic [7:0] a1_wd, a0_wd, a1_bc, a0_bc;

    always #5 clk = ~clk;

    spi_frame_deserializer #(.ADDR_W(7), .DATA_W(8), .MAX_ADDR(MAX), .AUTO_INC(1)) dut (
        .spi_clk(clk), .rst(rst), .cs(cs), .pico(pico),
        .addr(a1_addr), .is_write(a1_iw), .wdata(a1_wd), .wr_strobe(a1_ws),
        .rd_load(a1_rl), .frame_active(a1_fa), .addr_err(a1_ae), .byte_cnt(a1_bc)
    );

    spi_frame_deserializer #(.ADDR_W(7), .DATA_W(8), .MAX_ADDR(MAX), .AUTO_INC(0)) dut0 (
        .spi_clk(clk), .rst(rst), .cs(cs), .pico(pico),
        .addr(a0_addr), .is_write(a0_iw), .wdata(a0_wd), .wr_strobe(a0_ws),
        .rd_load(a0_rl), .frame_active(a0_fa), .addr_err(a0_ae), .byte_cnt(a0_bc)
    );

    typedef struct packed {
        logic [6:0] addr;
        logic       w;
        logic [7:0] wd;
        logic       ws;
        logic       rl;
        logic       fa;
        logic       ae;
        logic [7:0] bc;
    } exp_t;

    int checks = 0;
    int failures = 0;

    // Frame-level model state: bits seen in this frame and the completed bytes.
    int         nbits = 0;
    logic [7:0] cur = 8'h00;
    logic [7:0] fq[$];

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h expected=%0h", nm, $time, act, exp_v);
        end
    endtask

    function automatic exp_t model(input bit ai);
        exp_t       e;
        logic [7:0] cmd;
        logic [6:0] a;
        bit         err;
        int         k, inc;
        e = '0;
        if (nbits >= 8) begin
            cmd  = fq[0];
            e.fa = 1'b1;
            e.w  = cmd[7];
            a    = cmd[6:0];
            err  = (a == 7'd0) || (a > 7'(MAX));
            k    = nbits / 8 - 1;
            e.bc = (k > 255) ? 8'd255 : 8'(k);
            if (k >= 1) e.wd = fq[k];
            inc = (nbits >= 17) ? (nbits - 9) / 8 : 0;
            for (int i = 0; i < inc; i++) begin
                if (ai) begin
                    if (a == 7'(MAX)) begin
                        a   = 7'd1;
                        err = 1'b1;
                    end else begin
                        a = a + 7'd1;
                    end
                end
            end
            e.addr = a;
            e.ae   = err;
            if (e.w) e.ws = (k >= 1) && (nbits % 8 == 0) && (a >= 7'd1) && (a <= 7'(MAX));
            else     e.rl = (nbits == 8) || ((nbits >= 17) && (nbits % 8 == 1));
        end
        return e;
    endfunction

    task automatic cmp(input string tag, input exp_t g, input exp_t e);
        chk({tag, ".addr"},         int'(g.addr), int'(e.addr));
        chk({tag, ".is_write"},     int'(g.w),    int'(e.w));
        chk({tag, ".wdata"},        int'(g.wd),   int'(e.wd));
        chk({tag, ".wr_strobe"},    int'(g.ws),   int'(e.ws));
        chk({tag, ".rd_load"},      int'(g.rl),   int'(e.rl));
        chk({tag, ".frame_active"}, int'(g.fa),   int'(e.fa));
        chk({tag, ".addr_err"},     int'(g.ae),   int'(e.ae));
        chk({tag, ".byte_cnt"},     int'(g.bc),   int'(e.bc));
    endtask

    always @(posedge clk) begin
        if (rst || !cs) begin
            nbits = 0;
            cur   = 8'h00;
            fq.delete();
        end else begin
            cur = {cur[6:0], pico};
            nbits++;
            if (nbits % 8 == 0) fq.push_back(cur);
        end
    end

    always @(negedge clk) begin
        exp_t g1, g0;
        if (rst || !cs) begin
            nbits = 0;
            cur   = 8'h00;
            fq.delete();
        end
        g1 = {a1_addr, a1_iw, a1_wd, a1_ws, a1_rl, a1_fa, a1_ae, a1_bc};
        g0 = {a0_addr, a0_iw, a0_wd, a0_ws, a0_rl, a0_fa, a0_ae, a0_bc};
        cmp("inc1", g1, model(1'b1));
        cmp("inc0", g0, model(1'b0));
        chk("inc1.ws_rl_excl", int'(a1_ws & a1_rl), 0);
    end

    task automatic tick(input logic b);
        pico = b;
        @(posedge clk);
        @(negedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) tick(b[i]);
    endtask

    task automatic end_frame();
        cs   = 1'b0;
        pico = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #2;
        cs = 1'b1;
    endtask

    task automatic all_zero(input string nm);
        chk({nm, ".addr"}, int'(a1_addr), 0);
        chk({nm, ".fa"},   int'(a1_fa),   0);
        chk({nm, ".iw"},   int'(a1_iw),   0);
        chk({nm, ".ws"},   int'(a1_ws),   0);
        chk({nm, ".bc"},   int'(a1_bc),   0);
    endtask

    initial begin
        rst  = 1'b1;
        cs   = 1'b0;
        pico = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        all_zero("reset");
        rst = 1'b0;
        cs  = 1'b1;

        // Single write: 0x85 then 0x3C.
        send_byte(8'h85);
        chk("sw.is_write", int'(a1_iw), 1);
        chk("sw.addr_cmd", int'(a1_addr), 5);
        send_byte(8'h3C);
        chk("sw.strobe", int'(a1_ws), 1);
        chk("sw.addr_strobe", int'(a1_addr), 5);
        chk("sw.wdata", int'(a1_wd), 8'h3C);
        tick(1'b0);
        chk("sw.addr_inc", int'(a1_addr), 6);
        chk("sw.strobe_off", int'(a1_ws), 0);
        chk("sw.byte_cnt", int'(a1_bc), 1);
        end_frame();

        // Burst from address 10 across the wrap.
        send_byte(8'h8A);
        send_byte(8'hAA);
        chk("bw.s1_addr", int'(a1_addr), 10);
        chk("bw.s1_ws", int'(a1_ws), 1);
        send_byte(8'hBB);
        chk("bw.s2_addr", int'(a1_addr), 11);
        chk("bw.s2_addr_noinc", int'(a0_addr), 10);
        send_byte(8'hCC);
        chk("bw.s3_addr", int'(a1_addr), 1);
        chk("bw.s3_ws", int'(a1_ws), 1);
        chk("bw.s3_wdata", int'(a1_wd), 8'hCC);
        chk("bw.s3_addr_noinc", int'(a0_addr), 10);
        chk("bw.s3_ws_noinc", int'(a0_ws), 1);
        chk("bw.err", int'(a1_ae), 1);
        chk("bw.err_noinc", int'(a0_ae), 0);
        tick(1'b0);
        end_frame();

        // Invalid address 0.
        send_byte(8'h80);
        chk("inv.err_cmd", int'(a1_ae), 1);
        send_byte(8'h55);
        chk("inv.ws", int'(a1_ws), 0);
        chk("inv.bc", int'(a1_bc), 1);
        tick(1'b0);
        end_frame();

        // Read frame at address 2.
        send_byte(8'h02);
        chk("rd.rl_cmd", int'(a1_rl), 1);
        chk("rd.addr_cmd", int'(a1_addr), 2);
        send_byte(8'h00);
        chk("rd.rl_mid", int'(a1_rl), 0);
        tick(1'b0);
        chk("rd.rl_b1", int'(a1_rl), 1);
        chk("rd.addr_b1", int'(a1_addr), 3);
        repeat (7) tick(1'b0);
        end_frame();

        // Partial data byte aborted by cs, then a clean frame.
        send_byte(8'h83);
        tick(1'b1); tick(1'b0); tick(1'b1); tick(1'b0); tick(1'b1);
        cs = 1'b0;
        #1;
        all_zero("cs_abort");
        @(negedge clk);
        #2;
        cs = 1'b1;
        send_byte(8'h83);
        send_byte(8'h11);
        chk("pb.ws", int'(a1_ws), 1);
        chk("pb.addr", int'(a1_addr), 3);
        chk("pb.wdata", int'(a1_wd), 8'h11);
        tick(1'b0);
        end_frame();

        // Reset after four bits of a byte.
        send_byte(8'h85);
        repeat (4) tick(1'b1);
        rst = 1'b1;
        #1;
        all_zero("rst_abort");
        @(negedge clk);
        #2;
        rst = 1'b0;
        end_frame();
        send_byte(8'h81);
        send_byte(8'h77);
        chk("rr.ws", int'(a1_ws), 1);
        chk("rr.addr", int'(a1_addr), 1);
        tick(1'b0);
        end_frame();

        // Byte counter saturation.
        send_byte(8'h81);
        for (int i = 0; i < 256; i++) send_byte(8'(i));
        chk("sat.bc", int'(a1_bc), 255);
        end_frame();

        repeat (2) @(negedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
